// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Assembles big-endian 32-bit words from a valid/ready byte stream and writes
// them to consecutive word addresses from 0, holding the CPU until done.
// Optional checksum byte after the last word: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              csum_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CSUM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

  localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          byte_cnt;
  logic [ADDR_W:0]     word_cnt;
  logic [ADDR_W:0]     len_reg;
  logic [ADDR_W:0]     len_sat;
  logic [DATA_W-1:0]   asm_word;
  logic                accept;
  logic                start_ok;
  logic                last_word;

  assign len_sat   = (load_len > MAX_LEN) ? MAX_LEN : load_len;
  assign accept    = byte_valid && byte_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign last_word = ((word_cnt + CNT_ONE) == len_reg);
  assign mem_wdata = asm_word;

  // State register
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and Moore outputs
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) begin
          done     = 1'b1;
          cpu_hold = 1'b0;
        end
        if (start) state_nxt = (len_sat == '0) ? DONE : RECV;
      end
      RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid && (byte_cnt == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_nxt = last_word ? CSUM : RECV;
`else
        state_nxt = last_word ? DONE : RECV;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_nxt = DONE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Word assembly, address and word counters
  always_ff @(posedge clk) begin
    if (clr) begin
      mem_addr <= '0;
      byte_cnt <= '0;
      word_cnt <= '0;
      len_reg  <= '0;
      asm_word <= '0;
    end else if (start_ok) begin
      mem_addr <= '0;
      byte_cnt <= '0;
      word_cnt <= '0;
      len_reg  <= len_sat;
      asm_word <= '0;
    end else if ((state == RECV) && accept) begin
      // shifting in from the bottom leaves the first byte in the MSB lane
      asm_word <= {asm_word[DATA_W-9:0], byte_data};
      byte_cnt <= byte_cnt + 2'd1;
    end else if (state == WRITE) begin
      mem_addr <= mem_addr + ADDR_ONE;
      word_cnt <= word_cnt + CNT_ONE;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_err_r;

  // Running byte sum and sticky checksum result
  always_ff @(posedge clk) begin
    if (clr || start_ok) begin
      csum       <= '0;
      csum_err_r <= 1'b0;
    end else if ((state == RECV) && accept) begin
      csum <= csum + byte_data;
    end else if ((state == CSUM) && accept) begin
      csum_err_r <= ((csum + byte_data) != 8'd0);
    end
  end

  assign csum_err = csum_err_r;
`else
  assign csum_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: reset, table vectors, hand-written
// corner sequences and randomized loads against a word-list reference model.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              clr;
  logic              start;
  logic [ADDR_W:0]   load_len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              csum_err;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .clr(clr), .start(start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .csum_err(csum_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; int cyc; } wr_t;
  wr_t wq[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  logic [7:0] tx [0:1100];

  always @(posedge clk) cyc <= cyc + 1;

  // capture every write strobe cycle
  always @(negedge clk) if (mem_we === 1'b1) wq.push_back('{mem_addr, mem_wdata, cyc});

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W:0] len);
    @(negedge clk); load_len = len; start = 1'b1;
    @(negedge clk); start = 1'b0; load_len = 9'($urandom);
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random valid
  task automatic send_bytes(input int first, input int n, input int mode);
    int idx = first;
    int budget = 0;
    logic v;
    while (idx < first + n && budget < 20000) begin
      @(negedge clk); budget++;
      case (mode)
        1:       v = budget[0];
        2:       v = 1'($urandom_range(0, 1));
        default: v = 1'b1;
      endcase
      byte_valid = v;
      byte_data  = v ? tx[idx] : 8'($urandom);
      if (v && byte_ready) idx++;
    end
    @(negedge clk); byte_valid = 1'b0;
    chk("bytes_sent", 64'(idx - first), 64'(n));
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    chk("done_reached", {63'd0, done}, 64'd1);
  endtask

  task automatic finish_load(input int n, input int mode);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum = 8'd0;
    if (n > 0) begin
      for (int i = 0; i < 4 * n; i++) sum = sum + tx[i];
      tx[4 * n] = 8'd0 - sum;
      send_bytes(4 * n, 1, mode);
    end
`endif
    wait_done();
  endtask

  task automatic do_load(input logic [ADDR_W:0] len, input int mode);
    int n = (len > 256) ? 256 : int'(len);
    wq.delete();
    pulse_start(len);
    if (n > 0) send_bytes(0, 4 * n, mode);
    finish_load(n, mode);
  endtask

  // reference: word i is bytes 4i..4i+3 big-endian at address i mod 256
  task automatic check_model(input int n, input bit spacing);
    logic [DATA_W-1:0] w;
    chk("write_count", 64'(wq.size()), 64'(n));
    for (int i = 0; i < n && i < wq.size(); i++) begin
      w = {tx[4*i], tx[4*i+1], tx[4*i+2], tx[4*i+3]};
      chk("wr_addr", 64'(wq[i].addr), 64'(i % 256));
      chk("wr_data", 64'(wq[i].data), 64'(w));
      if (spacing && i > 0) chk("wr_spacing", 64'(wq[i].cyc - wq[i-1].cyc), 64'd5);
    end
    chk("post_cpu_hold", {63'd0, cpu_hold}, 64'd0);
    chk("post_busy", {63'd0, busy}, 64'd0);
    chk("post_byte_ready", {63'd0, byte_ready}, 64'd0);
    chk("post_csum_err", {63'd0, csum_err}, 64'd0);
  endtask

  typedef struct {
    logic [ADDR_W:0] len; int mode; logic [63:0] bytes;
    int exp_n; logic [31:0] w0; logic [31:0] w1;
  } vec_t;
  vec_t vt[4];

  initial begin
    vt[0] = '{9'd2, 0, 64'h2008000501095020, 2, 32'h20080005, 32'h01095020};
    vt[1] = '{9'd2, 1, 64'h2008000501095020, 2, 32'h20080005, 32'h01095020};
    vt[2] = '{9'd1, 2, 64'hDEADBEEF00000000, 1, 32'hDEADBEEF, 32'h0};
    vt[3] = '{9'd0, 0, 64'h1122334455667788, 0, 32'h0, 32'h0};

    clr = 1'b1; start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_hold", {63'd0, cpu_hold}, 64'd1);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_byte_ready", {63'd0, byte_ready}, 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_csum_err", {63'd0, csum_err}, 64'd0);
    clr = 1'b0;

    // len=0 from IDLE: DONE one edge after start, no writes
    wq.delete();
    pulse_start(9'd0);
    chk("len0_done", {63'd0, done}, 64'd1);
    chk("len0_cpu_hold", {63'd0, cpu_hold}, 64'd0);
    repeat (3) @(negedge clk);
    chk("len0_writes", 64'(wq.size()), 64'd0);

    // table vectors
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) tx[k] = vt[i].bytes[63 - 8*k -: 8];
      do_load(vt[i].len, vt[i].mode);
      chk("tbl_count", 64'(wq.size()), 64'(vt[i].exp_n));
      if (vt[i].exp_n > 0 && wq.size() > 0) begin
        chk("tbl_addr0", 64'(wq[0].addr), 64'd0);
        chk("tbl_w0", 64'(wq[0].data), 64'(vt[i].w0));
      end
      if (vt[i].exp_n > 1 && wq.size() > 1) begin
        chk("tbl_addr1", 64'(wq[1].addr), 64'd1);
        chk("tbl_w1", 64'(wq[1].data), 64'(vt[i].w1));
        if (vt[i].mode == 0) chk("tbl_spacing", 64'(wq[1].cyc - wq[0].cyc), 64'd5);
      end
      chk("tbl_done", {63'd0, done}, 64'd1);
      chk("tbl_cpu_hold", {63'd0, cpu_hold}, 64'd0);
    end

    // clr mid-word discards the partial word
    for (int k = 0; k < 8; k++) tx[k] = 8'($urandom);
    wq.delete();
    pulse_start(9'd2);
    send_bytes(0, 6, 0);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_cpu_hold", {63'd0, cpu_hold}, 64'd1);
    chk("clr_busy", {63'd0, busy}, 64'd0);
    chk("clr_done", {63'd0, done}, 64'd0);
    chk("clr_byte_ready", {63'd0, byte_ready}, 64'd0);
    chk("clr_mem_addr", 64'(mem_addr), 64'd0);
    repeat (10) @(negedge clk);
    chk("clr_partial_writes", 64'(wq.size()), 64'd1);
    for (int k = 0; k < 4; k++) tx[k] = 8'($urandom);
    do_load(9'd1, 0);
    check_model(1, 1'b1);

    // start during RECV is ignored
    for (int k = 0; k < 8; k++) tx[k] = 8'($urandom);
    wq.delete();
    pulse_start(9'd2);
    send_bytes(0, 3, 0);
    pulse_start(9'd1);
    send_bytes(3, 5, 0);
    finish_load(2, 0);
    check_model(2, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    tx[0] = 8'h01; tx[1] = 8'h02; tx[2] = 8'h03; tx[3] = 8'h04; tx[4] = 8'hF6;
    wq.delete();
    pulse_start(9'd1);
    send_bytes(0, 5, 0);
    wait_done();
    chk("ck_good_err", {63'd0, csum_err}, 64'd0);
    chk("ck_good_data", (wq.size() > 0) ? 64'(wq[0].data) : 64'd0, 64'h01020304);
    tx[4] = 8'h00;
    wq.delete();
    pulse_start(9'd1);
    send_bytes(0, 5, 0);
    wait_done();
    chk("ck_bad_err", {63'd0, csum_err}, 64'd1);
    chk("ck_bad_cpu_hold", {63'd0, cpu_hold}, 64'd0);
    pulse_start(9'd1);
    chk("ck_err_cleared", {63'd0, csum_err}, 64'd0);
    tx[4] = 8'hF6;
    send_bytes(0, 5, 0);
    wait_done();
`endif

    // randomized loads against the reference model
    for (int r = 0; r < 6; r++) begin
      int n;
      int mode;
      n    = $urandom_range(1, 6);
      mode = $urandom_range(0, 2);
      for (int k = 0; k < 4 * n; k++) tx[k] = 8'($urandom);
      do_load(9'(n), mode);
      check_model(n, mode == 0);
    end

    // oversize length saturates to 256 words; final increment wraps address
    for (int k = 0; k < 1024; k++) tx[k] = 8'($urandom);
    do_load(9'd300, 0);
    check_model(256, 1'b1);
    chk("sat_addr_wrap", 64'(mem_addr), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
